// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong reorder of bit-reversed FFT frames (valid_i/X_*_i in, no backpressure) into natural order over valid_o/ready_i with idx_o, last_o, sticky ovf_o
module fft_bitrev_reorder #(
  parameter int N    = 32,
  parameter int LOGN = 5,
  parameter int DW   = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [DW-1:0]   X_r_i,
  input  logic [DW-1:0]   X_i_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [DW-1:0]   X_r_o,
  output logic [DW-1:0]   X_i_o,
  output logic [LOGN-1:0] idx_o,
  output logic            last_o,
  output logic            ovf_o
);
  logic [DW-1:0]   mem_r [2*N];
  logic [DW-1:0]   mem_i [2*N];
  logic [LOGN-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, idx_q, idx_d, waddr;
  logic [1:0]      full_q, full_d;
  logic [DW-1:0]   xr_q, xr_d, xi_q, xi_d;
  logic            wbank_q, wbank_d, rbank_q, rbank_d, drop_q, drop_d;
  logic            valid_q, valid_d, last_q, last_d, ovf_q, ovf_d;
  logic            drop_now, wlast, we, load, rd, rlast;
  always_comb begin
    waddr = '0;
    for (int b = 0; b < LOGN; b++) waddr[b] = wcnt_q[LOGN-1-b];
  end
  always_comb begin
    drop_now = (wcnt_q == '0) ? full_q[wbank_q] : drop_q;
    wlast    = valid_i && (wcnt_q == LOGN'(N-1));
    we       = valid_i && !drop_now;
    load     = !valid_q || ready_i;
    rd       = load && full_q[rbank_q];
    rlast    = rd && (rcnt_q == LOGN'(N-1));
    wcnt_d   = valid_i ? wcnt_q + LOGN'(1) : wcnt_q;
    drop_d   = valid_i ? (!wlast && drop_now) : drop_q;
    wbank_d  = wbank_q ^ (wlast && !drop_now);
    ovf_d    = ovf_q | (valid_i && (wcnt_q == '0) && full_q[wbank_q]);
    full_d   = full_q;
    if (rlast) full_d[rbank_q] = 1'b0;
    if (wlast && !drop_now) full_d[wbank_q] = 1'b1;
    rbank_d  = rbank_q ^ rlast;
    rcnt_d   = rd ? rcnt_q + LOGN'(1) : rcnt_q;
    valid_d  = load ? full_q[rbank_q] : valid_q;
    xr_d     = rd ? mem_r[{rbank_q, rcnt_q}] : xr_q;
    xi_d     = rd ? mem_i[{rbank_q, rcnt_q}] : xi_q;
    idx_d    = rd ? rcnt_q : idx_q;
    last_d   = rd ? (rcnt_q == LOGN'(N-1)) : last_q;
  end
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[{wbank_q, waddr}] <= X_r_i;
      mem_i[{wbank_q, waddr}] <= X_i_i;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      full_q  <= '0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      xr_q    <= '0;
      xi_q    <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      xr_q    <= xr_d;
      xi_q    <= xi_d;
    end
  end
  assign valid_o = valid_q;
  assign X_r_o   = xr_q;
  assign X_i_o   = xi_q;
  assign idx_o   = idx_q;
  assign last_o  = last_q;
  assign ovf_o   = ovf_q;
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Sits directly downstream of the 32-point FFT core.
- Accepts the core's 32 complex results, which arrive in bit-reversed index order, qualified by the core's `finish` strobe.
- Re-emits each frame in natural order 0..31 over a valid/ready stream.
- Double-buffered (ping-pong, 2 banks x N entries), so frame n+1 is captured while frame n drains.

Parameters:
- N, 32, points per frame (power of 2)
- LOGN, 5, log2(N); index/counter width
- DW, 18, width of each real/imag component

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- valid_i  in  1  sample strobe; driven by FFT `finish`
- X_r_i  in  DW  real part of incoming sample
- X_i_i  in  DW  imag part of incoming sample
- ready_i  in  1  downstream accepts output this cycle
- valid_o  out  1  output sample valid
- X_r_o  out  DW  real part, natural order
- X_i_o  out  DW  imag part, natural order
- idx_o  out  LOGN  frequency index of current output
- last_o  out  1  high with idx_o == N-1
- ovf_o  out  1  sticky: at least one input frame dropped

Behaviour:
- Reset:
  - Active when rst_n = 0 at a clk edge.
  - Outputs: valid_o, last_o, ovf_o, idx_o, X_r_o, X_i_o all go to 0.
  - State: wcnt = 0, rcnt = 0, wbank = 0, rbank = 0, full[1:0] = 0, drop = 0.
  - Any partial input frame or undrained bank is discarded.
  - Memory contents need not be cleared.
- Write side (no backpressure; valid_i is never stalled):
  - A sample is captured on each edge with valid_i = 1.
  - The k-th sample of a frame (k = wcnt) is written to bank[wbank] at address bitrev(k), e.g. k = 1 -> addr 16, k = 3 -> addr 24.
  - Gaps (valid_i = 0) hold wcnt; frames need not be contiguous.
  - Drop decision at wcnt == 0 with valid_i = 1: if full[wbank] = 1, set drop = 1 for the whole frame. Writes are then suppressed and ovf_o is set. The decision holds even if the bank frees mid-frame.
  - On the sample with wcnt == N-1: wcnt -> 0.
    - drop = 0: set full[wbank] and toggle wbank.
    - drop = 1: clear drop, do not set full, do not toggle wbank.
- Read side / output register:
  - The output register loads when (!valid_o || ready_i).
  - On a load, if full[rbank] = 1: X_r_o/X_i_o <= bank[rbank][rcnt], idx_o <= rcnt, last_o <= (rcnt == N-1), valid_o <= 1, rcnt++.
  - On a load with full[rbank] = 0: valid_o <= 0; data outputs hold their values.
  - When the load of rcnt == N-1 occurs: clear full[rbank], toggle rbank, rcnt -> 0.
  - valid_o && !ready_i: all outputs hold unchanged.
- Latency:
  - Edge E0 captures the last sample of a frame into an empty read pipeline.
  - valid_o rises at edge E1 with idx_o = 0.
  - With ready_i = 1, indices 0..N-1 appear on N consecutive cycles.
  - If the other bank is already full, the next frame's idx 0 follows idx N-1 on the very next cycle (no bubble).
- Simultaneous events:
  - Setting full[a] (write) and clearing full[b] (read) on the same edge are independent and both take effect.
  - a == b cannot occur: a full bank is never written.
- Memory: read is combinational from the array into the registered outputs; a 1-write/1-read array per bank suffices.

Test Plan:
- Single frame, ready_i = 1: drive k = 0..31 with X_r_i = k, X_i_i = 100+k.
  - valid_o rises 1 edge after the last capture.
  - Output n carries X_r_o = bitrev(n) (n = 1 -> 16, n = 2 -> 8, n = 31 -> 31) and X_i_o = 100 + bitrev(n).
  - last_o high only at idx_o = 31; ovf_o stays 0.
- Input gaps: insert valid_i = 0 for 3 cycles after k = 7 and after k = 20.
  - Output order and values are identical to the single-frame case.
- Back-to-back: 3 contiguous frames (96 valid cycles), ready_i = 1.
  - 96 contiguous valid_o cycles; idx_o wraps 31 -> 0 with no bubble; ovf_o = 0.
- Backpressure: ready_i = 0 for 10 cycles starting at idx_o = 5.
  - idx_o = 5 and its data hold for those 10 cycles, then the sequence resumes at 6 with nothing lost or duplicated.
- Overflow: ready_i = 0 throughout while 3 frames (values 0x, 1x, 2x) are sent.
  - Frames 1 and 2 fill both banks; frame 3 is dropped and ovf_o = 1 from its first sample.
  - After raising ready_i, exactly 64 outputs appear (frames 1 and 2 only).
- Reset mid-operation: assert rst_n = 0 after 12 outputs of a frame, with the second bank half-written.
  - Next edge: valid_o = 0, ovf_o = 0, idx_o = 0.
  - A fresh frame then reproduces the single-frame results exactly.
